// File: rtl/nat_pkg.sv
// Shared key layout, field helpers, hash and FSM state type for the NAT connection table.
package nat_pkg;

    localparam int NAT_KEY_W    = 104;
    localparam int SRC_IP_LSB   = 72;
    localparam int DST_IP_LSB   = 40;
    localparam int SRC_PORT_LSB = 24;
    localparam int DST_PORT_LSB = 8;
    localparam int PROTO_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_RESP,
        ST_FLUSH
    } state_t;

    function automatic logic [31:0] key_src_ip(input logic [NAT_KEY_W-1:0] key);
        return key[SRC_IP_LSB +: 32];
    endfunction

    function automatic logic [31:0] key_dst_ip(input logic [NAT_KEY_W-1:0] key);
        return key[DST_IP_LSB +: 32];
    endfunction

    function automatic logic [15:0] key_src_port(input logic [NAT_KEY_W-1:0] key);
        return key[SRC_PORT_LSB +: 16];
    endfunction

    function automatic logic [15:0] key_dst_port(input logic [NAT_KEY_W-1:0] key);
        return key[DST_PORT_LSB +: 16];
    endfunction

    function automatic logic [7:0] key_proto(input logic [NAT_KEY_W-1:0] key);
        return key[PROTO_LSB +: 8];
    endfunction

    // Fold all five fields, then keep only the low hash_len bits as the home slot.
    function automatic logic [31:0] nat_hash(input logic [NAT_KEY_W-1:0] key, input int hash_len);
        logic [31:0] folded;
        folded = key_src_ip(key) ^ key_dst_ip(key)
               ^ {16'd0, key_src_port(key)} ^ {16'd0, key_dst_port(key)}
               ^ {24'd0, key_proto(key)};
        return folded & ((32'd1 << hash_len) - 32'd1);
    endfunction

endpackage

// File: rtl/nat_rr_arb.sv
// Two-way round-robin grant; grant is combinational from the valids, zero latency.
// Backpressure: no grant while en is low; the last-grant pointer moves only on an accepted grant.
module nat_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_gnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // A grant is only ever issued to a valid port, so every grant is an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b0;
        end else if (gnt0 || gnt1) begin
            last_gnt <= gnt1;
        end
    end

endmodule

// File: rtl/nat_conn_table_ctrl.sv
// NAT connection table: arbitrated lookup/insert over a linear-probed hash, plus a slot-by-slot flush.
// Response strobe two cycles after accept plus one per extra probe; ready stays low while busy or flushing.
module nat_conn_table_ctrl
    import nat_pkg::*;
#(
    parameter int HASH_LEN = 6,
    parameter int KEY_W    = NAT_KEY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [KEY_W-1:0]    req0_key,
    input  logic                req0_insert,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [KEY_W-1:0]    req1_key,
    input  logic                req1_insert,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                rsp_valid,
    output logic                rsp_port,
    output logic [HASH_LEN-1:0] rsp_id,
    output logic                rsp_hit,
    output logic                rsp_new,
    output logic                rsp_miss,
    output logic                rsp_err,
    output logic [HASH_LEN:0]   entry_count
);

    localparam int ID_SPACE = 2 ** HASH_LEN;

    state_t state, state_nxt;

    logic [KEY_W-1:0]    key_mem [ID_SPACE];
    logic [HASH_LEN-1:0] id_mem  [ID_SPACE];

    logic [KEY_W-1:0]    key_q;
    logic                ins_q, port_q, flush_pend;
    logic [HASH_LEN-1:0] slot, probe_cnt, sweep_ptr, next_id, id_q;
    logic [HASH_LEN:0]   count_q;
    logic                hit_q, new_q, miss_q, err_q;

    logic                arb_en, gnt0, gnt1, accept;
    logic [KEY_W-1:0]    acc_key, slot_key;
    logic                key_zero, slot_match, slot_empty, probe_last, resolve;
    logic                res_hit, res_new, res_miss, res_err, do_insert;

    assign arb_en = (state == ST_IDLE) && !flush_pend;

    nat_rr_arb u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign accept  = gnt0 || gnt1;
    assign acc_key = gnt1 ? req1_key : req0_key;

    // An all-zero request key would otherwise "match" every empty slot.
    assign slot_key   = key_mem[slot];
    assign key_zero   = (key_q == '0);
    assign slot_match = (slot_key == key_q);
    assign slot_empty = (slot_key == '0);
    assign probe_last = (probe_cnt == '1);
    assign resolve    = key_zero || slot_match || slot_empty || probe_last;

    assign res_hit   = !key_zero && slot_match;
    assign res_new   = !key_zero && !slot_match && slot_empty && ins_q;
    assign res_miss  = !key_zero && !slot_match && slot_empty && !ins_q;
    assign res_err   = key_zero || (!slot_match && !slot_empty);
    assign do_insert = (state == ST_PROBE) && res_new && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush_pend) begin
                    state_nxt = ST_FLUSH;
                end else if (accept) begin
                    state_nxt = ST_PROBE;
                end
            end
            ST_PROBE: if (resolve) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            ST_FLUSH: if (sweep_ptr == '1) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = gnt0;
        req1_ready  = gnt1;
        flush_busy  = (state == ST_FLUSH) && !rst;
        rsp_valid   = (state == ST_RESP);
        rsp_port    = rsp_valid && port_q;
        rsp_id      = rsp_valid ? id_q : '0;
        rsp_hit     = rsp_valid && hit_q;
        rsp_new     = rsp_valid && new_q;
        rsp_miss    = rsp_valid && miss_q;
        rsp_err     = rsp_valid && err_q;
        entry_count = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
            sweep_ptr  <= '0;
            next_id    <= '0;
            count_q    <= '0;
            key_q      <= '0;
            ins_q      <= 1'b0;
            port_q     <= 1'b0;
            slot       <= '0;
            probe_cnt  <= '0;
            hit_q      <= 1'b0;
            new_q      <= 1'b0;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
            id_q       <= '0;
        end else begin
            flush_pend <= (state == ST_FLUSH) ? 1'b0 : (flush_pend || flush_req);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        key_q     <= acc_key;
                        ins_q     <= gnt1 ? req1_insert : req0_insert;
                        port_q    <= gnt1;
                        slot      <= HASH_LEN'(nat_hash(acc_key, HASH_LEN));
                        probe_cnt <= '0;
                    end
                end
                ST_PROBE: begin
                    if (resolve) begin
                        hit_q  <= res_hit;
                        new_q  <= res_new;
                        miss_q <= res_miss;
                        err_q  <= res_err;
                        id_q   <= res_hit ? id_mem[slot] : (res_new ? next_id : '0);
                        if (res_new) begin
                            next_id <= next_id + HASH_LEN'(1);
                            count_q <= count_q + (HASH_LEN+1)'(1);
                        end
                    end else begin
                        slot      <= slot + HASH_LEN'(1);
                        probe_cnt <= probe_cnt + HASH_LEN'(1);
                    end
                end
                ST_FLUSH: begin
                    sweep_ptr <= sweep_ptr + HASH_LEN'(1);
                    if (sweep_ptr == '1) begin
                        next_id <= '0;
                        count_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_insert) begin
            key_mem[slot] <= key_q;
            id_mem[slot]  <= next_id;
        end
        if (state == ST_FLUSH) begin
            key_mem[sweep_ptr] <= '0;
        end
    end

endmodule
